// File: rtl/niosii_system_timer_driver.sv
// Avalon-MM master that programs a Nios II interval timer, services its timeouts,
// and takes counter snapshots on request.
module niosii_system_timer_driver #(
  parameter int CTRL_ITO_BIT  = 0,
  parameter int CTRL_CONT_BIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  input  logic [31:0] cfg_period,
  input  logic        cfg_continuous,
  input  logic        start_req,
  input  logic        stop_req,
  input  logic        snap_req,
  output logic        busy,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST,
    SN_WR, SN_RDL, SN_RDH, SN_CAP, STOP_WR
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_period;
  logic        r_cont;
  logic [15:0] r_cnt;
  logic [15:0] r_snap_lo;
  logic [31:0] r_snap;
  logic        r_stop_pend, r_snap_pend;
  logic        w_stop, w_snap;
  logic [15:0] w_ctrl;

  // A pulse arriving in the same RUN cycle is honoured immediately.
  assign w_stop = r_stop_pend | stop_req;
  assign w_snap = r_snap_pend | snap_req;
  assign w_ctrl = 16'h0004 | (16'h0001 << CTRL_ITO_BIT) | ({15'h0, r_cont} << CTRL_CONT_BIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_req) w_next = WR_PL;
      WR_PL:   w_next = WR_PH;
      WR_PH:   w_next = WR_CTRL;
      WR_CTRL: w_next = RUN;
      RUN: begin
        if (w_stop)       w_next = STOP_WR;
        else if (tmr_irq) w_next = CLR_ST;
        else if (w_snap)  w_next = SN_WR;
      end
      CLR_ST:  w_next = r_cont ? RUN : IDLE;
      SN_WR:   w_next = SN_RDL;
      SN_RDL:  w_next = SN_RDH;
      SN_RDH:  w_next = SN_CAP;
      SN_CAP:  w_next = RUN;
      STOP_WR: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    case (r_state)
      WR_PL:   begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd2; tmr_writedata = r_period[15:0];  end
      WR_PH:   begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd3; tmr_writedata = r_period[31:16]; end
      WR_CTRL: begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = w_ctrl;          end
      CLR_ST:  begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd0; end
      SN_WR:   begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd4; end
      SN_RDL:  begin tmr_chipselect = 1'b1; tmr_address = 3'd4; end
      SN_RDH:  begin tmr_chipselect = 1'b1; tmr_address = 3'd5; end
      STOP_WR: begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = 16'h0008; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_period    <= '0;
      r_cont      <= 1'b0;
      r_cnt       <= '0;
      r_snap_lo   <= '0;
      r_snap      <= '0;
      r_stop_pend <= 1'b0;
      r_snap_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_req) begin
        r_period <= cfg_period;
        r_cont   <= cfg_continuous;
        r_cnt    <= '0;
      end
      if (r_state == CLR_ST) r_cnt <= r_cnt + 16'd1;
      // Read data lags the address by one cycle: low half lands in SN_RDH, high in SN_CAP.
      if (r_state == SN_RDH) r_snap_lo <= tmr_readdata;
      if (r_state == SN_CAP) r_snap    <= {tmr_readdata, r_snap_lo};
      r_stop_pend <= w_stop;
      r_snap_pend <= w_snap;
      if (r_state == IDLE || (r_state == RUN && w_next == STOP_WR)) begin
        r_stop_pend <= 1'b0;
        r_snap_pend <= 1'b0;
      end else if (r_state == RUN && w_next == SN_WR) begin
        r_snap_pend <= 1'b0;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign tick       = (r_state == CLR_ST);
  assign tick_count = r_cnt;
  assign snap_valid = (r_state == SN_CAP);
  assign snap_value = (r_state == SN_CAP) ? {tmr_readdata, r_snap_lo} : r_snap;

endmodule

// File: tb/tb_niosii_system_timer_driver.sv
// Directed bench: stimulus queues expected bus accesses / tick / snapshot events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_niosii_system_timer_driver;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = 16'h0000;
  logic        tmr_irq;
  logic [31:0] cfg_period;
  logic        cfg_continuous, start_req, stop_req, snap_req;
  logic        busy, tick, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snap_value;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;   // 0 bus access, 1 tick, 2 snapshot
    logic [2:0]  addr;
    logic        wn;
    logic [31:0] data;
  } ev_t;
  ev_t q[$];

  niosii_system_timer_driver dut (
    .clk(clk), .reset_n(reset_n),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
    .start_req(start_req), .stop_req(stop_req), .snap_req(snap_req),
    .busy(busy), .tick(tick), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  // Slave read data: one cycle after the read address cycle.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? 16'h1234 :
                      (tmr_address == 3'd5) ? 16'h0000 : 16'hBEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [2:0] addr, input logic wn, input logic [31:0] data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.wn = wn; e.data = data;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [2:0] addr, input logic wn, input logic [31:0] data);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d wn=%0b data=0x%0h expected none",
               kind, addr, wn, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == 0 && (e.addr !== addr || e.wn !== wn ||
          (!wn && e.data !== data))) || (kind == 2 && e.data !== data)) begin
        bad++;
        $display("FAIL event: got kind=%0d addr=%0d wn=%0b data=0x%0h expected kind=%0d addr=%0d wn=%0b data=0x%0h",
                 kind, addr, wn, data, e.kind, e.addr, e.wn, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (tmr_chipselect) pop_chk(0, tmr_address, tmr_write_n, {16'h0, tmr_writedata});
      if (tick)           pop_chk(1, 3'd0, 1'b0, 32'h0);
      if (snap_valid)     pop_chk(2, 3'd0, 1'b0, snap_value);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called at a negedge in RUN; returns at a negedge back in RUN (or IDLE for one-shot).
  task automatic fire_irq();
    tmr_irq = 1'b1;
    push(0, 3'd0, 1'b0, 32'h0);
    push(1, 3'd0, 1'b0, 32'h0);
    @(negedge clk);
    tmr_irq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; tmr_irq = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
    start_req = 1'b0; stop_req = 1'b0; snap_req = 1'b0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_cs", tmr_chipselect, 0);
    chk("rst_tick_count", tick_count, 0);
    chk("rst_snap_value", snap_value, 0);
    reset_n = 1'b1;
    cyc(1);

    // continuous start
    cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1; start_req = 1'b1;
    push(0, 3'd2, 1'b0, 32'h86A0);
    push(0, 3'd3, 1'b0, 32'h0001);
    push(0, 3'd1, 1'b0, 32'h0007);
    cyc(1);
    start_req = 1'b0;
    chk("start_busy", busy, 1);
    cyc(3);

    for (int i = 0; i < 3; i++) fire_irq();
    chk("cont_tick_count", tick_count, 3);
    chk("cont_busy", busy, 1);
    cyc(2);

    // snapshot
    snap_req = 1'b1;
    push(0, 3'd4, 1'b0, 32'h0);
    push(0, 3'd4, 1'b1, 32'h0);
    push(0, 3'd5, 1'b1, 32'h0);
    push(2, 3'd0, 1'b0, 32'h0000_1234);
    cyc(1);
    snap_req = 1'b0;
    cyc(4);
    chk("snap_value_held", snap_value, 32'h0000_1234);
    chk("snap_busy", busy, 1);

    // stop and snap together: stop only
    stop_req = 1'b1; snap_req = 1'b1;
    push(0, 3'd1, 1'b0, 32'h0008);
    cyc(1);
    stop_req = 1'b0; snap_req = 1'b0;
    cyc(1);
    chk("stop_busy", busy, 0);
    chk("stop_tick_count", tick_count, 3);

    // irq in IDLE does nothing
    tmr_irq = 1'b1;
    cyc(3);
    chk("idle_irq_busy", busy, 0);
    tmr_irq = 1'b0;
    cyc(1);

    // one-shot
    cfg_period = 32'h0000_0010; cfg_continuous = 1'b0; start_req = 1'b1;
    push(0, 3'd2, 1'b0, 32'h0010);
    push(0, 3'd3, 1'b0, 32'h0000);
    push(0, 3'd1, 1'b0, 32'h0005);
    cyc(1);
    start_req = 1'b0;
    cyc(3);
    chk("oneshot_count_cleared", tick_count, 0);
    fire_irq();
    chk("oneshot_busy", busy, 0);
    chk("oneshot_tick_count", tick_count, 1);
    cyc(2);

    // reset during WR_PH
    cfg_period = 32'hAAAA_5555; cfg_continuous = 1'b1; start_req = 1'b1;
    push(0, 3'd2, 1'b0, 32'h5555);
    push(0, 3'd3, 1'b0, 32'hAAAA);
    cyc(1);
    start_req = 1'b0;
    cyc(1);
    #2 reset_n = 1'b0;
    cyc(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cs", tmr_chipselect, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_snap_value", snap_value, 0);
    chk("midrst_tick_count", tick_count, 0);
    reset_n = 1'b1;
    cyc(4);
    chk("midrst_idle_after", busy, 0);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
